// File: rtl/mant_mul24_seq_if.sv
// mant_mul24_seq_if: operand/product handshake bundle for the iterative mantissa multiplier.
interface mant_mul24_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] a;
    logic [23:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] p;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/mant_mul24_seq.sv
// mant_mul24_seq: 24x24 unsigned mantissa multiplier reusing one vedic12 over four cycles,
// accumulating shifted 24-bit partial products into a 48-bit product.
module vedic12 (
    input  logic [11:0] x,
    input  logic [11:0] y,
    output logic [23:0] z
);
    logic [11:0] ll, lh, hl, hh;
    // vertical-and-crosswise split into 6-bit halves
    assign ll = 12'(x[5:0]) * 12'(y[5:0]);
    assign lh = 12'(x[5:0]) * 12'(y[11:6]);
    assign hl = 12'(x[11:6]) * 12'(y[5:0]);
    assign hh = 12'(x[11:6]) * 12'(y[11:6]);
    assign z  = {hh, ll} + {6'd0, lh, 6'd0} + {6'd0, hl, 6'd0};
endmodule

module mant_mul24_seq (
    input  logic             clk,
    input  logic             rst_n,
    mant_mul24_seq_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2;
    logic [1:0]  state, cnt;
    logic [23:0] ra, rb, pp;
    logic [47:0] acc, term;

    // cnt[1] picks the A half, cnt[0] the B half; shift follows the sum of half indices
    vedic12 u_vedic (
        .x (cnt[1] ? ra[23:12] : ra[11:0]),
        .y (cnt[0] ? rb[23:12] : rb[11:0]),
        .z (pp)
    );

    always_comb term = cnt == 2'd0 ? {24'd0, pp} : cnt == 2'd3 ? {pp, 24'd0} : {12'd0, pp, 12'd0};

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.busy      = state != IDLE;
    assign bus.p         = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 2'd0;
            ra    <= 24'd0;
            rb    <= 24'd0;
            acc   <= 48'd0;
        end else if (state == IDLE && bus.in_valid) begin
            ra    <= bus.a;
            rb    <= bus.b;
            acc   <= 48'd0;
            cnt   <= 2'd0;
            state <= MUL;
        end else if (state == MUL) begin
            acc   <= acc + term;
            cnt   <= cnt + 2'd1;
            state <= cnt == 2'd3 ? DONE : MUL;
        end else if (state == DONE && bus.out_ready) begin
            state <= IDLE;
        end else if (state == 2'd3) begin
            state <= IDLE;
        end
    end
endmodule
